mmio_datamem: RTL

Parametrised data-memory subsystem for the computer top: word-addressed data RAM plus a configurable bank of memory-mapped input and output channels behind a request/ready handshake. Each access takes a programmable number of wait states, so the CPU can be run against slow memory or I/O. It connects to the CPU data port (ALU address, store data, load data, write enable) and exports the I/O channels to board pins.

---
 rtl/mmio_datamem_if.sv | 27 ++
 rtl/mmio_datamem.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_datamem_if.sv
// mmio_datamem_if: CPU data-port bundle for the mmio_datamem subsystem.
//
// Signals
//   req   : access request, held high with stable we/addr/wdata until ready
//   we    : 1 = write, 0 = read
//   addr  : byte address, addr[1:0] ignored
//   wdata : store data
//   rdata : load data, valid while ready = 1
//   ready : one-cycle completion pulse
//   err   : pulses with ready when the access hit an unimplemented location
//
// Handshake: the master raises req and keeps we/addr/wdata stable until it
// sees ready. The slave accepts the request only while idle, and it produces
// exactly one ready pulse per accepted access. If req is still high in the
// cycle after ready, the slave treats it as a new request.
interface mmio_datamem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output req, we, addr, wdata, input rdata, ready, err);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/mmio_datamem.sv
// mmio_datamem: word-addressed data RAM plus memory-mapped I/O channels,
// served through a request/ready handshake with programmable wait states.
//
// Address map (only addr[7:0] is decoded):
//   0x00..0x7F : RAM words. Locations at or above 4*2^ADDR_W flag err.
//   0x80..0xBF : input channel addr[4:2], read-only (synchronised io_in).
//   0xC0..0xFF : output register addr[4:2], read/write.
//   A channel index >= IO_CH flags err.
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : slave side of the CPU data port (see mmio_datamem_if)
//   io_in_i  : 32*IO_CH asynchronous input channels, channel i at [32i+31:32i]
//   io_out_o : 32*IO_CH registered output channels, same packing
//   state_o  : current FSM state (0 idle, 1 wait, 2 done), for debug
module mmio_datamem #(
  parameter int ADDR_W = 6,
  parameter int IO_CH  = 4,
  parameter int WAIT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mmio_datamem_if.slave         bus,
  input  logic [32*IO_CH-1:0]   io_in_i,
  output logic [32*IO_CH-1:0]   io_out_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0]  WAIT_L    = 3'(WAIT);
  localparam logic [31:0] RAM_BYTES = 32'(4) << ADDR_W;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] io_out_q [IO_CH];
  logic [31:0] sync1_q  [IO_CH];
  logic [31:0] sync2_q  [IO_CH];
  logic [31:0] ram_q    [2**ADDR_W];

  // The edge that enters DONE commits writes and captures read data. With
  // WAIT = 0 that edge is the acceptance edge, so the request is taken
  // straight from the bus. Otherwise the latched copy is used.
  logic              in_idle;
  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic              enter_done;
  logic              is_ram;
  logic              is_in;
  logic              is_out;
  logic              ram_oob;
  logic              ch_ok;
  logic [2:0]        ch;
  logic [ADDR_W-1:0] ram_idx;
  logic              acc_err;
  logic [31:0]       rd_val;
  logic              ram_we;

  always_comb begin
    in_idle    = (state_q == S_IDLE);
    acc_we     = in_idle ? bus.we    : we_q;
    acc_addr   = in_idle ? bus.addr  : addr_q;
    acc_wdata  = in_idle ? bus.wdata : wdata_q;
    enter_done = (in_idle && bus.req && (WAIT == 0)) ||
                 ((state_q == S_WAIT) && (cnt_q == 3'd1));

    is_ram  = !acc_addr[7];
    is_in   = (acc_addr[7:6] == 2'b10);
    is_out  = (acc_addr[7:6] == 2'b11);
    ram_oob = is_ram && ({24'd0, acc_addr[7:0]} >= RAM_BYTES);
    ch      = acc_addr[4:2];
    ch_ok   = (int'({29'd0, ch}) < IO_CH);
    ram_idx = acc_addr[ADDR_W+1:2];

    acc_err = ram_oob || (is_in && (acc_we || !ch_ok)) || (is_out && !ch_ok);

    rd_val = '0;
    if (is_ram && !ram_oob) begin
      rd_val = ram_q[ram_idx];
    end
    for (int i = 0; i < IO_CH; i++) begin
      if (ch == 3'(i)) begin
        if (is_in)  rd_val = sync2_q[i];
        if (is_out) rd_val = io_out_q[i];
      end
    end

    // Gating with rst_n keeps a WAIT = 0 request from committing on an edge
    // that arrives while reset is held.
    ram_we = enter_done && acc_we && is_ram && !ram_oob && rst_n;
  end

  // RAM is deliberately not reset, so contents survive a reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= acc_wdata;
    end
  end

  // Two-flop synchroniser per input channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IO_CH; i++) begin
        sync1_q[i] <= '0;
        sync2_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < IO_CH; i++) begin
        sync1_q[i] <= io_in_i[32*i +: 32];
        sync2_q[i] <= sync1_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < IO_CH; i++) begin
        io_out_q[i] <= '0;
      end
    end else begin
      ready_q <= enter_done;
      err_q   <= enter_done && acc_err;
      if (enter_done) begin
        rdata_q <= acc_we ? 32'd0 : rd_val;
        if (acc_we && is_out) begin
          for (int i = 0; i < IO_CH; i++) begin
            if (ch == 3'(i)) io_out_q[i] <= acc_wdata;
          end
        end
      end

      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            cnt_q   <= WAIT_L;
            state_q <= (WAIT == 0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 3'd1) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    io_out_o = '0;
    for (int i = 0; i < IO_CH; i++) begin
      io_out_o[32*i +: 32] = io_out_q[i];
    end
  end

  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign state_o   = state_q;

endmodule
